// File: rtl/lcd_window_scaler.sv
// Frame-buffer window mapper: turns VGA coordinates into read addresses for an
// integer-upscaled source image and emits registered RGB555 with matched sideband delay.
module lcd_window_scaler #(
    parameter int unsigned SRC_W     = 160,
    parameter int unsigned SRC_H     = 144,
    parameter int unsigned MAX_SCALE = 3,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        VGAX,
    input  logic [9:0]        VGAY,
    input  logic              vde_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [9:0]        cfg_x0,
    input  logic [9:0]        cfg_y0,
    input  logic [1:0]        cfg_scale,
    input  logic [14:0]       cfg_border,
    input  logic              cfg_gray,
    output logic              VGA_fetch,
    output logic [ADDR_W-1:0] VGA_addr,
    input  logic [14:0]       VGA_data,
    output logic [4:0]        Red,
    output logic [4:0]        Green,
    output logic [4:0]        Blue,
    output logic              vde_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SRC_W);
    localparam logic [1:0]        SCALE_MAX = 2'(MAX_SCALE);

    typedef struct packed {
        logic        vde;
        logic        hsync;
        logic        vsync;
        logic        win;
        logic        gray;
        logic [14:0] fill;
    } side_t;

    // Configuration shadows
    logic [9:0]  sh_x0;
    logic [9:0]  sh_y0;
    logic [1:0]  sh_scale;
    logic [14:0] sh_border;
    logic        sh_gray;
    logic [1:0]  scale_req;
    logic        frame_origin;

    // Address-generation state
    logic [ADDR_W-1:0] src_x, src_x_cur, src_x_nxt;
    logic [1:0]        sub_x, sub_x_cur, sub_x_nxt;
    logic              h_armed, h_armed_cur;
    logic [ADDR_W-1:0] row_base, row_base_cur;
    logic [1:0]        sub_y, sub_y_cur;
    logic              v_armed, v_armed_cur;

    // Window evaluation
    logic [10:0] x_span, y_span, x_end, y_end;
    logic        in_x, in_y, win_raw, window;
    logic [ADDR_W-1:0] addr_cur;

    // Pipeline
    logic              fetch_q;
    logic [ADDR_W-1:0] addr_q;
    side_t             side_in;
    side_t             side_q [0:RD_LAT];
    side_t             side_o;
    logic [14:0]       pix, pix_out;
    logic [6:0]        luma_sum;

    assign frame_origin = (VGAX == '0) && (VGAY == '0);

    always_comb begin
        scale_req = cfg_scale;
        if (cfg_scale == 2'd0) begin
            scale_req = 2'd1;
        end else if (cfg_scale > SCALE_MAX) begin
            scale_req = SCALE_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_x0     <= 10'd240;
            sh_y0     <= 10'd168;
            sh_scale  <= 2'd1;
            sh_border <= '0;
            sh_gray   <= 1'b0;
        end else if (frame_origin) begin
            sh_x0     <= cfg_x0;
            sh_y0     <= cfg_y0;
            sh_scale  <= scale_req;
            sh_border <= cfg_border;
            sh_gray   <= cfg_gray;
        end
    end

    always_comb begin
        x_span = 11'(SRC_W);
        y_span = 11'(SRC_H);
        if (sh_scale == 2'd2) begin
            x_span = 11'(SRC_W * 2);
            y_span = 11'(SRC_H * 2);
        end else if (sh_scale == 2'd3) begin
            x_span = 11'(SRC_W * 3);
            y_span = 11'(SRC_H * 3);
        end
    end

    assign x_end   = {1'b0, sh_x0} + x_span;
    assign y_end   = {1'b0, sh_y0} + y_span;
    assign in_x    = (VGAX >= sh_x0) && ({1'b0, VGAX} < x_end);
    assign in_y    = (VGAY >= sh_y0) && ({1'b0, VGAY} < y_end);
    assign win_raw = vde_in && in_x && in_y;

    // Vertical state steps once per line; the current line sees the updated value.
    always_comb begin
        row_base_cur = row_base;
        sub_y_cur    = sub_y;
        v_armed_cur  = v_armed;
        if (VGAX == '0) begin
            if (VGAY == sh_y0) begin
                row_base_cur = '0;
                sub_y_cur    = '0;
                v_armed_cur  = 1'b1;
            end else if (in_y) begin
                if (sub_y == sh_scale - 2'd1) begin
                    sub_y_cur    = '0;
                    row_base_cur = row_base + ROW_STEP;
                end else begin
                    sub_y_cur = sub_y + 2'd1;
                end
            end
        end
    end

    always_comb begin
        src_x_cur   = src_x;
        sub_x_cur   = sub_x;
        h_armed_cur = h_armed;
        if (VGAX == sh_x0) begin
            src_x_cur   = '0;
            sub_x_cur   = '0;
            h_armed_cur = 1'b1;
        end
        src_x_nxt = src_x_cur;
        sub_x_nxt = sub_x_cur;
        if (win_raw) begin
            if (sub_x_cur == sh_scale - 2'd1) begin
                sub_x_nxt = '0;
                src_x_nxt = src_x_cur + 1'b1;
            end else begin
                sub_x_nxt = sub_x_cur + 2'd1;
            end
        end
    end

    // Counters left stale by a mid-frame reset are not trusted until reloaded.
    assign window   = win_raw && h_armed_cur && v_armed_cur;
    assign addr_cur = row_base_cur + src_x_cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_x    <= '0;
            sub_x    <= '0;
            h_armed  <= 1'b0;
            row_base <= '0;
            sub_y    <= '0;
            v_armed  <= 1'b0;
        end else begin
            src_x    <= src_x_nxt;
            sub_x    <= sub_x_nxt;
            h_armed  <= h_armed_cur;
            row_base <= row_base_cur;
            sub_y    <= sub_y_cur;
            v_armed  <= v_armed_cur;
        end
    end

    always_comb begin
        side_in.vde   = vde_in;
        side_in.hsync = hsync_in;
        side_in.vsync = vsync_in;
        side_in.win   = window;
        side_in.gray  = sh_gray;
        side_in.fill  = vde_in ? sh_border : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_q <= 1'b0;
            addr_q  <= '0;
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                side_q[k] <= '0;
            end
        end else begin
            fetch_q   <= window;
            addr_q    <= window ? addr_cur : '0;
            side_q[0] <= side_in;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                side_q[k] <= side_q[k-1];
            end
        end
    end

    assign VGA_fetch = fetch_q;
    assign VGA_addr  = addr_q;

    always_comb begin
        side_o   = side_q[RD_LAT];
        pix      = side_o.win ? VGA_data : side_o.fill;
        luma_sum = 7'(pix[14:10]) + {1'b0, pix[9:5], 1'b0} + 7'(pix[4:0]);
        pix_out  = pix;
        if (side_o.gray) begin
            pix_out = {3{luma_sum[6:2]}};
        end
        if (!side_o.vde) begin
            pix_out = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            vde_out   <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            Red       <= pix_out[14:10];
            Green     <= pix_out[9:5];
            Blue      <= pix_out[4:0];
            vde_out   <= side_o.vde;
            hsync_out <= side_o.hsync;
            vsync_out <= side_o.vsync;
        end
    end

endmodule

// File: tb/tb_lcd_window_scaler.sv
// Bench for lcd_window_scaler: two builds (scale cap 3 / latency 1 and scale cap 2 / latency 4)
// driven by one short synthetic raster, checked against an arithmetic window model.
module tb_lcd_window_scaler;

    localparam int W     = 16;
    localparam int H     = 12;
    localparam int AW    = 8;
    localparam int LAT_A = 3;
    localparam int LAT_B = 6;
    localparam int HTOT  = 72;
    localparam int VTOT  = 54;
    localparam int ACT_W = 64;
    localparam int ACT_H = 48;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  VGAX = '0, VGAY = '0;
    logic        vde_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [9:0]  cfg_x0 = '0, cfg_y0 = '0;
    logic [1:0]  cfg_scale = '0;
    logic [14:0] cfg_border = '0;
    logic        cfg_gray = 1'b0;

    logic          fetch_a, fetch_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [14:0]   data_a, data_b;
    logic [4:0]    r_a, g_a, b_a, r_b, g_b, b_b;
    logic          vde_a, hs_a, vs_a, vde_b, hs_b, vs_b;

    logic [14:0] mem [0:255];
    logic [14:0] pipe_a;
    logic [14:0] pipe_b [0:3];

    logic [31:0] ofa_a, ofa_b, opx_a, opx_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit pend_release = 1'b0;
    int e_fa_a [0:7];
    int e_px_a [0:7];
    int e_fa_b [0:7];
    int e_px_b [0:7];

    int sh_x0, sh_y0, sh_scale, sh_border, sh_gray;
    bit synced;
    int f_x0, f_y0, f_scale, f_border, f_gray;

    always #5 clk = ~clk;

    lcd_window_scaler #(.SRC_W(W), .SRC_H(H), .MAX_SCALE(3), .RD_LAT(1), .ADDR_W(AW)) dut_a (
        .clk(clk), .reset_n(reset_n), .VGAX(VGAX), .VGAY(VGAY),
        .vde_in(vde_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_scale(cfg_scale),
        .cfg_border(cfg_border), .cfg_gray(cfg_gray),
        .VGA_fetch(fetch_a), .VGA_addr(addr_a), .VGA_data(data_a),
        .Red(r_a), .Green(g_a), .Blue(b_a),
        .vde_out(vde_a), .hsync_out(hs_a), .vsync_out(vs_a)
    );

    lcd_window_scaler #(.SRC_W(W), .SRC_H(H), .MAX_SCALE(2), .RD_LAT(4), .ADDR_W(AW)) dut_b (
        .clk(clk), .reset_n(reset_n), .VGAX(VGAX), .VGAY(VGAY),
        .vde_in(vde_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_scale(cfg_scale),
        .cfg_border(cfg_border), .cfg_gray(cfg_gray),
        .VGA_fetch(fetch_b), .VGA_addr(addr_b), .VGA_data(data_b),
        .Red(r_b), .Green(g_b), .Blue(b_b),
        .vde_out(vde_b), .hsync_out(hs_b), .vsync_out(vs_b)
    );

    // Frame-buffer models; unrequested cycles return junk so stray use shows up.
    always @(posedge clk) begin
        pipe_a    <= fetch_a ? mem[addr_a] : 15'($urandom);
        pipe_b[0] <= fetch_b ? mem[addr_b] : 15'($urandom);
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign data_a = pipe_a;
    assign data_b = pipe_b[3];

    assign ofa_a = {15'b0, fetch_a, 8'b0, addr_a};
    assign ofa_b = {15'b0, fetch_b, 8'b0, addr_b};
    assign opx_a = {14'b0, vde_a, hs_a, vs_a, r_a, g_a, b_a};
    assign opx_b = {14'b0, vde_b, hs_b, vs_b, r_b, g_b, b_b};

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        sh_x0 = 240; sh_y0 = 168; sh_scale = 1; sh_border = 0; sh_gray = 0;
        synced = 1'b0;
    endtask

    // Expected fetch/address and pixel for one coordinate, from window arithmetic.
    task automatic model_pixel(input int x, input int y, input int vde, input int hs,
                               input int vs, input int max_s, output int fa, output int px);
        int s, addr, c, lum;
        bit win;
        s = (sh_scale == 0) ? 1 : ((sh_scale > max_s) ? max_s : sh_scale);
        win = synced && vde != 0 && x >= sh_x0 && x < sh_x0 + W * s &&
              y >= sh_y0 && y < sh_y0 + H * s;
        addr = win ? ((y - sh_y0) / s) * W + (x - sh_x0) / s : 0;
        fa = win ? ((1 << 16) | addr) : 0;
        c = (vde == 0) ? 0 : (win ? int'(mem[addr]) : sh_border);
        if (sh_gray != 0) begin
            lum = (((c >> 10) & 31) + 2 * ((c >> 5) & 31) + (c & 31)) >> 2;
            c = lum * 1057;
        end
        px = (vde << 17) | (hs << 16) | (vs << 15) | c;
    endtask

    task automatic step(input int x, input int y);
        int vde, hs, vs, fa, px;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            check("fa_a_rst", ofa_a, 0);
            check("px_a_rst", opx_a, 0);
            check("fa_b_rst", ofa_b, 0);
            check("px_b_rst", opx_b, 0);
        end else begin
            if (cyc >= 1) check("fa_a", ofa_a, e_fa_a[(cyc - 1) % 8]);
            if (cyc >= 1) check("fa_b", ofa_b, e_fa_b[(cyc - 1) % 8]);
            if (cyc >= LAT_A) check("px_a", opx_a, e_px_a[(cyc - LAT_A) % 8]);
            if (cyc >= LAT_B) check("px_b", opx_b, e_px_b[(cyc - LAT_B) % 8]);
        end
        if (pend_release) begin
            reset_n = 1'b1;
            pend_release = 1'b0;
        end
        vde = (x < ACT_W && y < ACT_H) ? 1 : 0;
        hs  = (x >= 66 && x < 70) ? 1 : 0;
        vs  = (y >= 50 && y < 52) ? 1 : 0;
        VGAX = 10'(x); VGAY = 10'(y);
        vde_in = vde[0]; hsync_in = hs[0]; vsync_in = vs[0];
        if (x == 0 && y == 0) begin
            cfg_x0 = 10'(f_x0); cfg_y0 = 10'(f_y0); cfg_scale = 2'(f_scale);
            cfg_border = 15'(f_border); cfg_gray = f_gray[0];
        end else begin
            cfg_x0 = 10'($urandom); cfg_y0 = 10'($urandom); cfg_scale = 2'($urandom);
            cfg_border = 15'($urandom); cfg_gray = 1'($urandom);
        end
        if (!reset_n) begin
            e_fa_a[cyc % 8] = 0; e_px_a[cyc % 8] = 0;
            e_fa_b[cyc % 8] = 0; e_px_b[cyc % 8] = 0;
        end else begin
            model_pixel(x, y, vde, hs, vs, 3, fa, px);
            e_fa_a[cyc % 8] = fa; e_px_a[cyc % 8] = px;
            model_pixel(x, y, vde, hs, vs, 2, fa, px);
            e_fa_b[cyc % 8] = fa; e_px_b[cyc % 8] = px;
            if (x == 0 && y == 0) begin
                sh_x0 = f_x0; sh_y0 = f_y0; sh_scale = f_scale;
                sh_border = f_border; sh_gray = f_gray;
                synced = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic run_frame(input int x0, input int y0, input int sc, input int border,
                             input int gray, input int ry, input int rx);
        int hold;
        hold = 0;
        f_x0 = x0; f_y0 = y0; f_scale = sc; f_border = border; f_gray = gray;
        for (int y = 0; y < VTOT; y++) begin
            for (int x = 0; x < HTOT; x++) begin
                step(x, y);
                if (y == ry && x == rx) begin
                    #2 reset_n = 1'b0;
                    #1;
                    check("async_fa_a", ofa_a, 0);
                    check("async_px_a", opx_a, 0);
                    check("async_fa_b", ofa_b, 0);
                    check("async_px_b", opx_b, 0);
                    e_fa_a[(cyc - 1) % 8] = 0; e_px_a[(cyc - 1) % 8] = 0;
                    e_fa_b[(cyc - 1) % 8] = 0; e_px_b[(cyc - 1) % 8] = 0;
                    model_reset();
                    hold = 6;
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) pend_release = 1'b1;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 15'($urandom);
        mem[0] = 15'h7C00;
        mem[1] = 15'h7FFF;
        for (int i = 0; i < 8; i++) begin
            e_fa_a[i] = 0; e_px_a[i] = 0; e_fa_b[i] = 0; e_px_b[i] = 0;
        end
        model_reset();
        f_x0 = 0; f_y0 = 0; f_scale = 0; f_border = 0; f_gray = 0;
        for (int i = 0; i < 4; i++) step(1, 60);
        pend_release = 1'b1;

        run_frame(20, 10, 1, int'($urandom_range(0, 32767)), 0, -1, -1);
        run_frame(8, 4, 3, int'($urandom_range(0, 32767)), 0, -1, -1);
        run_frame(40, 30, 3, int'($urandom_range(0, 32767)), 0, -1, -1);
        run_frame(3, 2, 0, int'($urandom_range(0, 32767)), 1, -1, -1);
        run_frame(12, 6, 2, 15'h03E0, 1, -1, -1);
        run_frame(10, 5, 2, int'($urandom_range(0, 32767)), 0, 12, 20);
        run_frame(10, 5, 2, int'($urandom_range(0, 32767)), 0, -1, -1);
        for (int f = 0; f < 2; f++) begin
            run_frame(int'($urandom_range(1, 40)), int'($urandom_range(1, 30)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 32767)),
                      int'($urandom_range(0, 1)), -1, -1);
        end
        for (int i = 0; i < 8; i++) step(1, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
